// File: rtl/imem_run_sequencer.sv
// imem_run_sequencer
// Loads a program into the miniMips instruction memory from a host stream,
// pulses the core's start input for one cycle, then waits for the core's
// done signal while a watchdog counts run cycles.
//
// Ports:
//   clk, reset_n              clock and asynchronous active-low reset
//   host_valid/host_ready     program-word handshake. A word transfers on a
//                             rising edge where both are 1. host_ready is 1
//                             only in IDLE and only while reset_n is high.
//   host_data, host_last      program word and end-of-program marker
//   load_req, run_req         host commands (discard program / run program)
//   imem_we/addr/wdata        registered instruction-memory write port
//   core_start, core_done     core control: start pulse and done flag
//   busy                      high while the core is starting or running
//   status                    00 none, 01 OK, 10 TIMEOUT, 11 OVERFLOW
//   prog_len                  word count of the loaded program
//   cycle_count               RUN cycles in the last or current run
//   dbg_state                 current FSM state, for observation only
module imem_run_sequencer #(
   parameter int IW         = 9,
   parameter int AW         = 8,
   parameter int MAX_CYCLES = 1024
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          host_valid,
   output logic          host_ready,
   input  logic [IW-1:0] host_data,
   input  logic          host_last,
   input  logic          load_req,
   input  logic          run_req,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [IW-1:0] imem_wdata,
   output logic          core_start,
   input  logic          core_done,
   output logic          busy,
   output logic [1:0]    status,
   output logic [AW:0]   prog_len,
   output logic [15:0]   cycle_count,
   output logic [1:0]    dbg_state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READY = 2'd1;
   localparam logic [1:0] S_START = 2'd2;
   localparam logic [1:0] S_RUN   = 2'd3;

   localparam logic [1:0] ST_NONE     = 2'b00;
   localparam logic [1:0] ST_OK       = 2'b01;
   localparam logic [1:0] ST_TIMEOUT  = 2'b10;
   localparam logic [1:0] ST_OVERFLOW = 2'b11;

   localparam logic [15:0] LIMIT = 16'(MAX_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic          imem_we_q, imem_we_d;
   logic [AW-1:0] imem_addr_q, imem_addr_d;
   logic [IW-1:0] imem_wdata_q, imem_wdata_d;
   logic [1:0]    status_q, status_d;
   logic [AW:0]   prog_len_q, prog_len_d;
   logic [15:0]   cycle_count_q, cycle_count_d;
   logic          xfer;

   // Gating with reset_n keeps host_ready low during reset even though the
   // state register already reads IDLE.
   assign host_ready = reset_n && (state_q == S_IDLE);
   assign xfer       = host_valid && host_ready;

   always_comb begin
      state_d       = state_q;
      wptr_d        = wptr_q;
      imem_we_d     = 1'b0;
      imem_addr_d   = imem_addr_q;
      imem_wdata_d  = imem_wdata_q;
      status_d      = status_q;
      prog_len_d    = prog_len_q;
      cycle_count_d = cycle_count_q;

      case (state_q)
         S_IDLE: begin
            // load_req restarts the load; a word offered in the same cycle
            // is dropped along with the partial program.
            if (load_req) begin
               wptr_d = '0;
            end else if (xfer) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = wptr_q;
               imem_wdata_d = host_data;
               if (host_last) begin
                  prog_len_d = {1'b0, wptr_q} + (AW+1)'(1);
                  wptr_d     = '0;
                  state_d    = S_READY;
               end else if (wptr_q == '1) begin
                  // Memory full without an end marker: program is unusable.
                  status_d   = ST_OVERFLOW;
                  prog_len_d = '0;
                  wptr_d     = '0;
               end else begin
                  wptr_d = wptr_q + AW'(1);
               end
            end
         end
         S_READY: begin
            if (load_req) begin
               wptr_d     = '0;
               prog_len_d = '0;
               state_d    = S_IDLE;
            end else if (run_req) begin
               state_d = S_START;
            end
         end
         S_START: begin
            cycle_count_d = '0;
            status_d      = ST_NONE;
            state_d       = S_RUN;
         end
         S_RUN: begin
            // The count is held on the terminating edge so it reports the
            // number of RUN edges before completion; done beats timeout.
            if (core_done) begin
               status_d = ST_OK;
               state_d  = S_READY;
            end else if (cycle_count_q == LIMIT) begin
               status_d = ST_TIMEOUT;
               state_d  = S_READY;
            end else if (cycle_count_q != 16'hFFFF) begin
               cycle_count_d = cycle_count_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         wptr_q        <= '0;
         imem_we_q     <= 1'b0;
         imem_addr_q   <= '0;
         imem_wdata_q  <= '0;
         status_q      <= ST_NONE;
         prog_len_q    <= '0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wptr_q        <= wptr_d;
         imem_we_q     <= imem_we_d;
         imem_addr_q   <= imem_addr_d;
         imem_wdata_q  <= imem_wdata_d;
         status_q      <= status_d;
         prog_len_q    <= prog_len_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign imem_we     = imem_we_q;
   assign imem_addr   = imem_addr_q;
   assign imem_wdata  = imem_wdata_q;
   assign core_start  = (state_q == S_START);
   assign busy        = (state_q == S_START) || (state_q == S_RUN);
   assign status      = status_q;
   assign prog_len    = prog_len_q;
   assign cycle_count = cycle_count_q;
   assign dbg_state   = state_q;

endmodule

// File: doc/imem_run_sequencer.md
# imem_run_sequencer

Sequences the miniMips core for a host: streams a 9-bit program into instruction memory, issues a single-cycle `start` pulse to `topLevel`, then watches `done` under a cycle watchdog. Sits between the host/test harness and the core, driving the instruction-memory write port and the core's `start` input. Reports the outcome and the run length.

## Interface

- `IW`, 9: instruction word width.
- `AW`, 8: instruction memory address width; capacity is 2^AW words.
- `MAX_CYCLES`, 1024: watchdog limit in RUN cycles. Legal range is 1..65535.

- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `host_valid` in 1: a program word is offered.
- `host_ready` out 1: the block accepts a word. Transfer occurs when `host_valid` and `host_ready` are both 1 at a clock edge.
- `host_data` in IW: the program word.
- `host_last` in 1: marks the final word of the program.
- `load_req` in 1: discard the current program and return to IDLE.
- `run_req` in 1: request a run of the loaded program.
- `imem_we` out 1: instruction memory write enable.
- `imem_addr` out AW: instruction memory write address.
- `imem_wdata` out IW: instruction memory write data.
- `core_start` out 1: the core's `start` input.
- `core_done` in 1: the core's `done` output.
- `busy` out 1: high in START and RUN.
- `status` out 2: 00 none, 01 OK, 10 TIMEOUT, 11 OVERFLOW.
- `prog_len` out AW+1: number of words in the loaded program.
- `cycle_count` out 16: number of RUN cycles in the last or current run.

## Operation

- **States:** IDLE, READY, START, RUN.
- **IDLE**
  - `host_ready`=1.
  - Each transfer writes `host_data` to address `wptr`, then increments `wptr`.
  - A transfer with `host_last`=1 sets `prog_len` = `wptr`+1, clears `wptr`, and goes to READY.
  - A transfer at `wptr` = 2^AW−1 with `host_last`=0 sets `status`=11, clears `wptr`, sets `prog_len`=0, and stays in IDLE. That word is still written.
  - `run_req` is ignored in IDLE.
- **READY**
  - `host_ready`=0.
  - `run_req` goes to START.
  - `load_req` clears `wptr` and `prog_len` and goes to IDLE.
  - If both are asserted in the same cycle, `load_req` wins.
- **START**
  - `core_start`=1 for exactly this one cycle.
  - `cycle_count` and `status` are cleared to 0.
  - Next state is RUN unconditionally.
- **RUN**
  - `cycle_count` increments each cycle and saturates at 0xFFFF.
  - `core_done`=1 sets `status`=01 and goes to READY.
  - Otherwise, when `cycle_count` = MAX_CYCLES−1 is sampled, set `status`=10 and go to READY.
  - If `core_done` and the timeout occur in the same cycle, OK wins.
  - `load_req` and `run_req` are ignored in START and RUN.
- `core_done` is ignored outside RUN.
- `status` holds its value until the next START, OVERFLOW, or reset.
- In IDLE, `load_req` clears `wptr` and drops any partial program. `status` is unchanged.

## Timing

- **Reset (asynchronous, active-low):**
  - State goes to IDLE.
  - `host_ready` deasserts while `reset_n` is low and reads 1 in IDLE once reset is released.
  - All other outputs read 0: `imem_we`, `imem_addr`, `imem_wdata`, `core_start`, `busy`, `status`, `prog_len`, `cycle_count`, and internal `wptr`.
  - A reset during RUN aborts the run. No status is recorded.
- **Memory writes are registered.** A word accepted at edge N appears on `imem_we`/`imem_addr`/`imem_wdata` during cycle N..N+1. `imem_we` is low in every cycle with no transfer.
- **Start latency.** With `run_req` sampled at edge N in READY, `core_start` is high for the one period after edge N. RUN begins at edge N+1.
- **Write-before-start.** The last write always completes before `core_start`, because READY lasts at least one cycle.
- **`cycle_count` on completion.** It equals the number of RUN-cycle edges before the edge where `core_done` is sampled. If `core_done` is high in the first RUN cycle, `cycle_count`=0 and `status`=01.
- **Back-to-back transfers** are supported at one word per clock.

## Test plan

- **Normal load:** load 7 words with `host_last` on the 7th. Expect writes to addresses 0..6 with matching data, then READY with `prog_len`=7 and `host_ready`=0.
- **Normal run:** `run_req` in READY, and the core model asserts `core_done` on the 5th RUN cycle. Expect `core_start` high for exactly 1 cycle, `busy` high for 6 cycles, `status`=01, `cycle_count`=4, and return to READY.
- **Timeout:** with MAX_CYCLES=16 and `core_done` never asserted, expect `status`=10, `cycle_count`=15, and READY.
- **Simultaneous done and timeout:** `core_done` rises in the same cycle `cycle_count`=15 with MAX_CYCLES=16. Expect `status`=01.
- **Overflow:** load 256 words with no `host_last`. Expect `status`=11, `prog_len`=0, the state stays IDLE, and a subsequent `run_req` produces no `core_start`.
- **Reset mid-run:** assert `reset_n`=0 on RUN cycle 3. Expect all outputs to go to 0 immediately, IDLE, and `host_ready`=1 after release. A `run_req` before any reload is ignored.
